// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver feeding a program loader: byte pairs become 12-bit
// instructions written sequentially into program memory from address 0.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PROG_LEN     = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        start,
  output logic        load_en,
  output logic [7:0]  load_addr,
  output logic [11:0] load_instr,
  output logic        load_done,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LOW, L_HIGH, L_WRITE, L_DONE} l_state_t;

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       LAST_ADDR = 8'(PROG_LEN - 1);

  logic rxd_meta, rxd_sync;

  rx_state_t        rx_state, rx_state_nx;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       rx_shift, rx_shift_nx;
  logic             rx_valid, rx_valid_nx;
  logic             frame_set;

  l_state_t    l_state, l_state_nx;
  logic [7:0]  load_addr_nx;
  logic [7:0]  instr_lo, instr_lo_nx;
  logic [11:0] load_instr_nx;
  logic        frame_clr;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values, forming a true 2-stage chain.
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      clk_cnt  <= clk_cnt_nx;
      bit_idx  <= bit_idx_nx;
      rx_shift <= rx_shift_nx;
      rx_valid <= rx_valid_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rx_state_nx = rx_state;
    clk_cnt_nx  = clk_cnt;
    bit_idx_nx  = bit_idx;
    rx_shift_nx = rx_shift;
    rx_valid_nx = 1'b0;
    frame_set   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          rx_state_nx = RX_START;
          clk_cnt_nx  = '0;
          bit_idx_nx  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nx  = '0;
          bit_idx_nx  = '0;
          rx_state_nx = rxd_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_nx  = '0;
          rx_shift_nx = {rxd_sync, rx_shift[7:1]};
          bit_idx_nx  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nx = RX_STOP;
        end else begin
          clk_cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (clk_cnt == CNT_FULL) begin
          clk_cnt_nx  = '0;
          rx_state_nx = RX_IDLE;
          if (rxd_sync) rx_valid_nx = 1'b1;
          else          frame_set   = 1'b1;
        end else begin
          clk_cnt_nx = clk_cnt + CNT_W'(1);
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // rx_shift holds the completed byte while rx_valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_state    <= L_IDLE;
      load_addr  <= '0;
      instr_lo   <= '0;
      load_instr <= '0;
    end else begin
      l_state    <= l_state_nx;
      load_addr  <= load_addr_nx;
      instr_lo   <= instr_lo_nx;
      load_instr <= load_instr_nx;
    end
  end

  always_comb begin
    l_state_nx    = l_state;
    load_addr_nx  = load_addr;
    instr_lo_nx   = instr_lo;
    load_instr_nx = load_instr;
    frame_clr     = 1'b0;
    load_en       = 1'b0;
    busy          = 1'b0;
    load_done     = 1'b0;
    unique case (l_state)
      L_IDLE, L_DONE: begin
        load_done = (l_state == L_DONE);
        if (start) begin
          l_state_nx   = L_LOW;
          load_addr_nx = '0;
          frame_clr    = 1'b1;
        end
      end
      L_LOW: begin
        busy = 1'b1;
        if (rx_valid) begin
          instr_lo_nx = rx_shift;
          l_state_nx  = L_HIGH;
        end
      end
      L_HIGH: begin
        busy = 1'b1;
        if (rx_valid) begin
          load_instr_nx = {rx_shift[3:0], instr_lo};
          l_state_nx    = L_WRITE;
        end
      end
      L_WRITE: begin
        busy    = 1'b1;
        load_en = 1'b1;
        if (load_addr == LAST_ADDR) begin
          l_state_nx   = L_DONE;
          load_addr_nx = '0;
        end else begin
          l_state_nx   = L_LOW;
          load_addr_nx = load_addr + 8'd1;
        end
      end
      default: l_state_nx = L_IDLE;
    endcase
  end

  // A new framing error wins over a same-cycle clear from start.
  always_ff @(posedge clk) begin
    if (rst)            frame_err <= 1'b0;
    else if (frame_set) frame_err <= 1'b1;
    else if (frame_clr) frame_err <= 1'b0;
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every load_en pulse.
module tb_uart_prog_loader;

  localparam int CPB = 16;
  localparam int PL  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        start = 1'b0;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [11:0] load_instr;
  logic        load_done;
  logic        busy;
  logic        frame_err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [11:0] instr;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_en = 1'b0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .PROG_LEN(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .start      (start),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_instr (load_instr),
    .load_done  (load_done),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && load_en) begin
      check("load_en_one_cycle", {31'd0, prev_en}, 32'd0);
      check("busy_during_write", {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {24'd0, load_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {24'd0, load_addr}, {24'd0, e.addr});
        check("write_instr", {20'd0, load_instr}, {20'd0, e.instr});
      end
    end
    prev_en <= load_en;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [7:0] d;
    d = b;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop_bit;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [11:0] ins);
    wr_t w;
    w.addr  = a;
    w.instr = ins;
    exp_q.push_back(w);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!load_done && n < 2000) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, load_done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_en"},    {31'd0, load_en},    32'd0);
    check({tag, "_load_addr"},  {24'd0, load_addr},  32'd0);
    check({tag, "_load_instr"}, {20'd0, load_instr}, 32'd0);
    check({tag, "_load_done"},  {31'd0, load_done},  32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    // Byte while idle is discarded; glitch and mid-load start are ignored.
    send_byte(8'h77, 1'b1);
    push(8'd0, 12'h3A5);
    push(8'd1, 12'hF3C);
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    check("glitch_frame_err", {31'd0, frame_err}, 32'd0);
    send_byte(8'hA5, 1'b1);
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_done("load1_done");
    check("load1_addr", {24'd0, load_addr}, 32'd0);
    check("load1_busy", {31'd0, busy}, 32'd0);
    check("load1_frame_err", {31'd0, frame_err}, 32'd0);

    // Reload from L_DONE overwrites from address 0.
    push(8'd0, 12'hC5A);
    push(8'd1, 12'h7FF);
    pulse_start();
    check("reload_done_clears", {31'd0, load_done}, 32'd0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h0C, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hF7, 1'b1);
    wait_done("load2_done");

    // Framing error on the high byte; the resend fills the same half.
    push(8'd0, 12'h3A5);
    push(8'd1, 12'hF3C);
    pulse_start();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b0);
    check("frame_err_set", {31'd0, frame_err}, 32'd1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_done("load3_done");
    check("frame_err_sticky", {31'd0, frame_err}, 32'd1);

    // Start clears frame_err; reset during second byte's data bits abandons it.
    pulse_start();
    check("start_clears_frame_err", {31'd0, frame_err}, 32'd0);
    send_byte(8'hA5, 1'b1);
    rxd = 1'b0;
    tick(CPB + 3 * CPB);
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    tick(20);
    push(8'd0, 12'h412);
    push(8'd1, 12'h856);
    pulse_start();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    wait_done("load4_done");
    check("load4_addr", {24'd0, load_addr}, 32'd0);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the number of clk cycles per UART bit period; legal values are even and >= 4.
REQ-002 Parameter PROG_LEN, default 26, is the number of 12-bit instructions per program load; legal range is 1..256.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rxd  in  1  asynchronous UART serial input, 8N1, LSB first, idles high.
REQ-006 start  in  1  single-cycle request to begin a program load.
REQ-007 load_en  out  1  program-memory load enable (write strobe).
REQ-008 load_addr  out  8  program-memory load address.
REQ-009 load_instr  out  12  program-memory load data.
REQ-010 load_done  out  1  high when the full program has been written.
REQ-011 busy  out  1  high while a load is in progress.
REQ-012 frame_err  out  1  sticky flag; set when a stop bit is sampled low.

Function
REQ-013 rxd shall pass through a 2-flop synchronizer; every use below refers to the synchronized value.
REQ-014 The receive FSM shall have four states: RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-015 RX_IDLE to RX_START: synchronized rxd sampled low; the bit counter clears.
REQ-016 RX_START, after CLKS_PER_BIT/2 cycles: rxd low goes to RX_DATA; rxd high counts as a glitch and returns to RX_IDLE with no byte.
REQ-017 RX_DATA shall sample 8 bits, one every CLKS_PER_BIT cycles, shifting LSB first, then go to RX_STOP.
REQ-018 RX_STOP, after CLKS_PER_BIT cycles:
- stop bit high: byte valid for one cycle;
- stop bit low: set frame_err and discard the byte;
- either case: return to RX_IDLE.
REQ-019 The load FSM shall have five states: L_IDLE, L_LOW, L_HIGH, L_WRITE and L_DONE.
REQ-020 L_IDLE or L_DONE, on start=1: go to L_LOW, clear load_addr to 0, clear load_done and frame_err.
REQ-021 start shall be ignored in L_LOW, L_HIGH and L_WRITE.
REQ-022 Bytes received while in L_IDLE or L_DONE shall be discarded.
REQ-023 L_LOW, on a valid byte: latch it as instr[7:0], then go to L_HIGH.
REQ-024 L_HIGH, on a valid byte: latch byte[3:0] as instr[11:8] (byte[7:4] ignored), then go to L_WRITE.
REQ-025 L_WRITE shall last exactly one cycle, with load_en=1 and load_addr/load_instr stable and valid.
REQ-026 On leaving L_WRITE, load_addr shall increment by 1.
REQ-027 Leaving L_WRITE when the write was at address PROG_LEN-1: go to L_DONE and set load_addr to 0. Otherwise: go to L_LOW.
REQ-028 In L_DONE, load_done=1 and is held until start or rst.
REQ-029 busy=1 exactly in L_LOW, L_HIGH and L_WRITE.
REQ-030 load_en shall be 0 in every state except L_WRITE.
REQ-031 A framing error shall not advance the byte phase; the next valid byte fills the same half.
REQ-032 load_addr arithmetic is 8-bit; with PROG_LEN=256 the address wraps from 255 to 0 on completion.

Reset
REQ-033 On rst=1, at the next clk edge:
- both FSMs go to their idle states (RX_IDLE, L_IDLE);
- load_en=0, load_addr=0, load_instr=0, load_done=0, busy=0, frame_err=0;
- synchronizer flops go to 1.
REQ-034 rst shall take priority over start and over any in-flight byte or write.
REQ-035 A reset mid-operation abandons the partial instruction; no load_en pulse is issued for it.

Verification
REQ-036 Scenario, normal load: PROG_LEN=2, CLKS_PER_BIT=16, start, then bytes 0xA5,0x03,0x3C,0x0F -> load_en pulses at addr 0 (0x3A5) and addr 1 (0xF3C), one cycle each; load_done=1; load_addr=0.
REQ-037 Scenario, glitch rejection: rxd low for 4 cycles during RX_IDLE -> no byte, no load_en, frame_err=0.
REQ-038 Scenario, framing error: the 0x03 byte is sent with a low stop bit, then 0x03 is resent -> frame_err=1; addr 0 is written as 0x3A5 once.
REQ-039 Scenario, ignored inputs: start pulsed after the first byte; a byte sent in L_IDLE -> load continues unaffected; the byte sent in L_IDLE is not written.
REQ-040 Scenario, reset mid-load: rst asserted during RX_DATA of the second byte -> all outputs at reset values; a new start plus a full program loads from addr 0.
REQ-041 Scenario, reload: start in L_DONE -> load_done clears the next cycle; a second program overwrites from addr 0.
